i2s_rx: RTL and testbench

Capture-side I2S deserializer for the Zynq audio path. It is the receive counterpart of the playback serializer that drives `audio_I2S_bclk/pbdat/pblrc`. It takes the codec record stream (BCLK, REC LRCLK, REC DATA) as asynchronous inputs and oversamples them in the fabric clock domain. It emits left/right sample pairs on a valid/ready interface toward the FIFO/DMA path.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_sync_edge.sv | 54 +++++
 rtl/i2s_rx.sv | 165 ++++++++++++++++
 tb/tb_i2s_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S types and default geometry for capture and playback
`timescale 1ns/1ps
package i2s_pkg;

    localparam int I2S_DATA_WIDTH_DEF = 24;
    localparam int I2S_SLOT_MAX_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LEFT,
        RIGHT
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - 2-FF pin synchronizers, BCLK rising-edge pulse, matched LRC/DAT taps
`timescale 1ns/1ps
module i2s_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic bclk_in,
    input  logic lrc_in,
    input  logic dat_in,
    output logic bclk_rise,
    output logic lrc,
    output logic dat
);

    // Index 0/1 are the synchronizer stages; bclk index 2 is the edge-detect history.
    logic [2:0] bclk_sh_q, bclk_sh_d;
    logic [1:0] lrc_sh_q, lrc_sh_d;
    logic [1:0] dat_sh_q, dat_sh_d;
    logic       rise_q, rise_d;
    logic       lrc_q, lrc_d;
    logic       dat_q, dat_d;

    always_comb begin
        bclk_sh_d = {bclk_sh_q[1:0], bclk_in};
        lrc_sh_d  = {lrc_sh_q[0], lrc_in};
        dat_sh_d  = {dat_sh_q[0], dat_in};
        // LRC/DAT are registered alongside the edge pulse so all three line up.
        rise_d    = bclk_sh_q[1] & ~bclk_sh_q[2];
        lrc_d     = lrc_sh_q[1];
        dat_d     = dat_sh_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sh_q <= '0;
            lrc_sh_q  <= '0;
            dat_sh_q  <= '0;
            rise_q    <= 1'b0;
            lrc_q     <= 1'b0;
            dat_q     <= 1'b0;
        end else begin
            bclk_sh_q <= bclk_sh_d;
            lrc_sh_q  <= lrc_sh_d;
            dat_sh_q  <= dat_sh_d;
            rise_q    <= rise_d;
            lrc_q     <= lrc_d;
            dat_q     <= dat_d;
        end
    end

    assign bclk_rise = rise_q;
    assign lrc       = lrc_q;
    assign dat       = dat_q;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S capture deserializer producing left/right pairs on a valid/ready port
`timescale 1ns/1ps
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH_DEF,
    parameter int SLOT_MAX   = I2S_SLOT_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  i2s_bclk,
    input  logic                  i2s_reclrc,
    input  logic                  i2s_recdat,
    output logic [DATA_WIDTH-1:0] m_left,
    output logic [DATA_WIDTH-1:0] m_right,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int CW = $clog2(SLOT_MAX);
    localparam logic [CW-1:0]         CNT_MAX = CW'(SLOT_MAX - 1);
    localparam logic [DATA_WIDTH-1:0] MSB_BIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic bclk_rise, lrc, dat;

    i2s_sync_edge u_sync_edge (
        .clk       (clk),
        .rst       (rst),
        .bclk_in   (i2s_bclk),
        .lrc_in    (i2s_reclrc),
        .dat_in    (i2s_recdat),
        .bclk_rise (bclk_rise),
        .lrc       (lrc),
        .dat       (dat)
    );

    i2s_rx_state_t         state_q, state_d;
    logic                  lrc_prev_q, lrc_prev_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic [DATA_WIDTH-1:0] m_left_q, m_left_d;
    logic [DATA_WIDTH-1:0] m_right_q, m_right_d;
    logic                  m_valid_q, m_valid_d;
    logic                  overrun_q, overrun_d;

    logic [DATA_WIDTH-1:0] shift_in;
    logic                  lrc_rise, lrc_fall;
    logic                  commit_right, load, drop;

    always_comb begin
        state_d      = state_q;
        lrc_prev_d   = lrc_prev_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        left_hold_d  = left_hold_q;
        m_left_d     = m_left_q;
        m_right_d    = m_right_q;
        m_valid_d    = m_valid_q;
        commit_right = 1'b0;

        // Bit index >= DATA_WIDTH shifts the mask out entirely, so late bits are dropped.
        shift_in = dat ? (shift_q | (MSB_BIT >> cnt_q)) : shift_q;
        lrc_rise = bclk_rise & ~lrc_prev_q & lrc;
        lrc_fall = bclk_rise & lrc_prev_q & ~lrc;

        if (bclk_rise) begin
            lrc_prev_d = lrc;
            shift_d    = shift_in;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // The transition rise still carries the old slot's last bit, hence shift_in on commit.
        case (state_q)
            IDLE: begin
                shift_d = '0;
                cnt_d   = '0;
                if (enable) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                shift_d = '0;
                cnt_d   = '0;
                if (lrc_fall) begin
                    state_d = LEFT;
                end
            end
            LEFT: begin
                if (lrc_rise) begin
                    left_hold_d = shift_in;
                    shift_d     = '0;
                    cnt_d       = '0;
                    state_d     = RIGHT;
                end
            end
            RIGHT: begin
                if (lrc_fall) begin
                    commit_right = 1'b1;
                    shift_d      = '0;
                    cnt_d        = '0;
                    state_d      = LEFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!enable) begin
            state_d      = IDLE;
            shift_d      = '0;
            cnt_d        = '0;
            commit_right = 1'b0;
        end

        load = commit_right & (~m_valid_q | m_ready);
        drop = commit_right & ~load;

        if (load) begin
            m_left_d  = left_hold_q;
            m_right_d = shift_in;
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        overrun_d = drop | (overrun_q & ~clr_overrun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lrc_prev_q  <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            m_left_q    <= '0;
            m_right_q   <= '0;
            m_valid_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrc_prev_q  <= lrc_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            m_left_q    <= m_left_d;
            m_right_q   <= m_right_d;
            m_valid_q   <= m_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign m_left  = m_left_q;
    assign m_right = m_right_q;
    assign m_valid = m_valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed scoreboard bench for i2s_rx
`timescale 1ns/1ps
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        i2s_bclk = 1'b0;
    logic        i2s_reclrc = 1'b0;
    logic        i2s_recdat = 1'b0;
    logic [23:0] m_left;
    logic [23:0] m_right;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        overrun;
    logic        clr_overrun = 1'b0;

    int checks = 0;
    int failures = 0;
    int valid_cycles = 0;
    logic pend = 1'b0;
    logic [47:0] exp_q[$];

    always #5 clk = ~clk;

    i2s_rx dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .i2s_bclk    (i2s_bclk),
        .i2s_reclrc  (i2s_reclrc),
        .i2s_recdat  (i2s_recdat),
        .m_left      (m_left),
        .m_right     (m_right),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake.
    always begin
        @(negedge clk);
        #1;
        if (m_valid) valid_cycles++;
        if (!rst && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pair actual=%h_%h required=none", m_left, m_right);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if ({m_left, m_right} !== e) begin
                    failures++;
                    $display("FAIL pair actual=%h_%h required=%h_%h", m_left, m_right, e[47:24], e[23:0]);
                end
            end
        end
    end

    // Codec side: LRC/DAT change on BCLK fall, data lags LRC by one bit.
    task automatic bclk_period(input logic lrc_v, input logic bit_v, input bit pulse);
        @(negedge clk);
        i2s_bclk   = 1'b0;
        i2s_reclrc = lrc_v;
        i2s_recdat = pend;
        pend       = bit_v;
        repeat (16) @(negedge clk);
        i2s_bclk = 1'b1;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (pulse && i == 3) m_ready = 1'b1;
            if (pulse && i == 4) m_ready = 1'b0;
        end
    endtask

    task automatic send_slot(input logic lrc_v, input logic [31:0] w32, input int slot);
        logic [31:0] w;
        w = w32;
        for (int k = 0; k < slot; k++) begin
            bclk_period(lrc_v, w[31], 1'b0);
            w = w << 1;
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, {l, 8'h00}, 32);
        send_slot(1'b1, {r, 8'h00}, 32);
    endtask

    task automatic restart();
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) bclk_period(1'b1, 1'b0, 1'b0);
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int vc0;
        repeat (4) @(negedge clk);
        check("reset_m_valid", {31'd0, m_valid}, 32'd0);
        check("reset_m_left", {8'd0, m_left}, 32'd0);
        check("reset_m_right", {8'd0, m_right}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;

        // Basic pair with consumer always ready
        m_ready = 1'b1;
        restart();
        vc0 = valid_cycles;
        exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
        send_frame(24'hA5A5A5, 24'h5A5A5A);
        bclk_period(1'b0, 1'b0, 1'b0);
        settle();
        check("basic_valid_cycles", valid_cycles - vc0, 32'd1);
        check("basic_overrun", {31'd0, overrun}, 32'd0);
        check("basic_drained", exp_q.size(), 32'd0);

        // Back-pressure: second pair dropped, overrun set then cleared
        m_ready = 1'b0;
        restart();
        exp_q.push_back({24'h111111, 24'h222222});
        send_frame(24'h111111, 24'h222222);
        send_frame(24'h333333, 24'h444444);
        bclk_period(1'b0, 1'b0, 1'b0);
        settle();
        check("bp_overrun_set", {31'd0, overrun}, 32'd1);
        check("bp_valid_held", {31'd0, m_valid}, 32'd1);
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        @(negedge clk);
        check("bp_overrun_clr", {31'd0, overrun}, 32'd0);
        check("bp_drained", exp_q.size(), 32'd0);

        // 16-bit slots: unfilled LSBs are zero
        restart();
        exp_q.push_back({24'h123400, 24'hFEDC00});
        send_slot(1'b0, 32'h12340000, 16);
        send_slot(1'b1, 32'hFEDC0000, 16);
        bclk_period(1'b0, 1'b0, 1'b0);
        settle();
        check("short_drained", exp_q.size(), 32'd0);

        // Enable mid right slot: partial frame discarded
        @(negedge clk);
        enable = 1'b0;
        send_slot(1'b0, 32'h77777700, 32);
        send_slot(1'b1, 32'h88888800, 16);
        enable = 1'b1;
        send_slot(1'b1, 32'h88880000, 16);
        exp_q.push_back({24'hABCDEF, 24'h012345});
        send_frame(24'hABCDEF, 24'h012345);
        bclk_period(1'b0, 1'b0, 1'b0);
        settle();
        check("en_drained", exp_q.size(), 32'd0);

        // Reset mid left slot
        m_ready = 1'b0;
        restart();
        fork
            begin
                send_frame(24'h0F0F0F, 24'hF0F0F0);
                send_frame(24'h666666, 24'h999999);
                send_frame(24'h13579B, 24'h2468AC);
                bclk_period(1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (74 * 32) @(negedge clk);
                check("rst_pre_valid", {31'd0, m_valid}, 32'd1);
                check("rst_pre_left", {8'd0, m_left}, 32'h000F0F0F);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_m_valid", {31'd0, m_valid}, 32'd0);
                check("rst_m_left", {8'd0, m_left}, 32'd0);
                check("rst_m_right", {8'd0, m_right}, 32'd0);
                check("rst_overrun", {31'd0, overrun}, 32'd0);
                m_ready = 1'b1;
                exp_q.push_back({24'h13579B, 24'h2468AC});
            end
        join
        settle();
        check("rst_drained", exp_q.size(), 32'd0);

        // Ready in the same cycle as a new right commit
        m_ready = 1'b0;
        restart();
        exp_q.push_back({24'hC0FFEE, 24'hBEEF01});
        exp_q.push_back({24'h800001, 24'h7FFFFE});
        send_frame(24'hC0FFEE, 24'hBEEF01);
        send_frame(24'h800001, 24'h7FFFFE);
        bclk_period(1'b0, 1'b0, 1'b1);
        settle();
        check("same_cycle_valid", {31'd0, m_valid}, 32'd1);
        check("same_cycle_overrun", {31'd0, overrun}, 32'd0);
        m_ready = 1'b1;
        settle();
        check("same_cycle_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
